data_mem_responder: RTL and testbench

- Word-addressed data memory that acts as the responder end of the load/store queue memory interface.
- Accepts one read request per cycle and returns data after a fixed, parameterised pipeline latency.
- Accepts one retire-time store write per cycle.
- Sits between the writeback/LSQ stage and the data array; it is the sole owner of architectural data memory state.

---
 rtl/data_mem_responder.sv | 97 +++++++++
 tb/tb_data_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory, responder side of the LSQ memory interface.
// One read and one full-word write per cycle; reads return after a fixed
// READ_LATENCY with data snapshotted at issue. The array is never reset.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter string       INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rd_en,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rdata_valid,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_misaligned
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]   mem_array [DEPTH];
    logic [IDX_W-1:0]        ridx;
    logic [IDX_W-1:0]        widx;
    logic [DATA_WIDTH-1:0]   issue_data;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
    logic                    misaligned_d;
    logic                    misaligned_q;
    logic                    unused_addr;

    // Upper address bits alias; byte offset only feeds the misaligned flag.
    assign ridx        = mem_raddr[2 +: IDX_W];
    assign widx        = mem_waddr[2 +: IDX_W];
    assign unused_addr = ^{mem_raddr[ADDR_WIDTH-1:IDX_W+2], mem_waddr[ADDR_WIDTH-1:IDX_W+2]};

    // Array write; reset is in the sensitivity list only so writes seen while
    // rst is low are dropped. Contents themselves are never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (rst && mem_write_en) begin
            mem_array[widx] <= mem_wdata;
        end
    end

    // Issue-stage data with write-first bypass for a same-index store.
    always_comb begin
        issue_data = mem_array[ridx];
        if (mem_write_en && (widx == ridx)) begin
            issue_data = mem_wdata;
        end
    end

    // Read pipeline; data only advances behind a valid so the last stage holds
    // the most recently returned word while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= mem_rd_en;
            if (mem_rd_en) begin
                pipe_data[0] <= issue_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    // Misaligned detection for either port this cycle.
    always_comb begin
        misaligned_d = (mem_rd_en && (mem_raddr[1:0] != 2'b00)) ||
                       (mem_write_en && (mem_waddr[1:0] != 2'b00));
    end

    // One-cycle informational flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign mem_rdata       = pipe_data[READ_LATENCY-1];
    assign mem_rdata_valid = pipe_valid[READ_LATENCY-1];
    assign mem_misaligned  = misaligned_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency 2 main instance plus latency
// 1 and 4 instances sharing the same stimulus.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [31:0] raddr;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    logic [31:0] rdata2, rdata1, rdata4;
    logic        valid2, valid1, valid4;
    logic        mis2, mis1, mis4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_rd_en(rd_en), .mem_raddr(raddr),
        .mem_rdata(rdata2), .mem_rdata_valid(valid2), .mem_write_en(we),
        .mem_waddr(waddr), .mem_wdata(wdata), .mem_misaligned(mis2)
    );

    data_mem_responder #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .mem_rd_en(rd_en), .mem_raddr(raddr),
        .mem_rdata(rdata1), .mem_rdata_valid(valid1), .mem_write_en(we),
        .mem_waddr(waddr), .mem_wdata(wdata), .mem_misaligned(mis1)
    );

    data_mem_responder #(.READ_LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst), .mem_rd_en(rd_en), .mem_raddr(raddr),
        .mem_rdata(rdata4), .mem_rdata_valid(valid4), .mem_write_en(we),
        .mem_waddr(waddr), .mem_wdata(wdata), .mem_misaligned(mis4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        we    = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rd_en = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        step(); step();
        check("reset_rdata", rdata2, 32'h0);
        check("reset_valid", {31'b0, valid2}, 32'h0);
        check("reset_mis",   {31'b0, mis2},   32'h0);
        rst = 1'b1;
        step();

        // Write then read 0x40, with latency sweep across instances.
        do_write(32'h40, 32'hDEADBEEF);
        step();
        rd_en = 1'b1; raddr = 32'h40;
        step();
        idle();
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("lat2_valid_k%0d", k), {31'b0, valid2}, {31'b0, k == 2});
            check($sformatf("lat1_valid_k%0d", k), {31'b0, valid1}, {31'b0, k == 1});
            check($sformatf("lat4_valid_k%0d", k), {31'b0, valid4}, {31'b0, k == 4});
            if (k == 1) check("lat1_data", rdata1, 32'hDEADBEEF);
            if (k == 2) check("lat2_data", rdata2, 32'hDEADBEEF);
            if (k == 4) check("lat4_data", rdata4, 32'hDEADBEEF);
            step();
        end
        check("hold_rdata", rdata2, 32'hDEADBEEF);

        // Same-cycle write and read to 0x80 returns the new data.
        we = 1'b1; waddr = 32'h80; wdata = 32'h12345678;
        rd_en = 1'b1; raddr = 32'h80;
        step();
        idle();
        step();
        check("bypass_valid", {31'b0, valid2}, 32'h1);
        check("bypass_data",  rdata2, 32'h12345678);

        // Write after issue is not visible to the in-flight read.
        rd_en = 1'b1; raddr = 32'h80;
        step();
        rd_en = 1'b0;
        do_write(32'h80, 32'hAAAAAAAA);
        check("snapshot_valid", {31'b0, valid2}, 32'h1);
        check("snapshot_data",  rdata2, 32'h12345678);
        step();

        // Back-to-back reads of words 1..4.
        for (int i = 0; i < 4; i++) do_write(32'(i * 4), 32'(i + 1));
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; raddr = 32'(i * 4);
            step();
            if (i >= 1) begin
                check($sformatf("b2b_valid_%0d", i - 1), {31'b0, valid2}, 32'h1);
                check($sformatf("b2b_data_%0d", i - 1), rdata2, 32'(i));
            end
        end
        idle();
        step();
        check("b2b_valid_3", {31'b0, valid2}, 32'h1);
        check("b2b_data_3",  rdata2, 32'h4);
        step();
        check("b2b_done", {31'b0, valid2}, 32'h0);

        // Reset with a read in flight: response is discarded, array kept.
        do_write(32'h10, 32'h55AA1234);
        rd_en = 1'b1; raddr = 32'h10;
        step();
        idle();
        rst = 1'b0;
        #1;
        check("rst_kill_rdata", rdata2, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("rst_low_valid_%0d", k), {31'b0, valid2}, 32'h0);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst_after_valid_%0d", k), {31'b0, valid2}, 32'h0);
        end
        rd_en = 1'b1; raddr = 32'h10;
        step();
        idle();
        step();
        check("retain_valid", {31'b0, valid2}, 32'h1);
        check("retain_data",  rdata2, 32'h55AA1234);

        // Misaligned read returns the aligned word and pulses the flag once.
        rd_en = 1'b1; raddr = 32'h42;
        step();
        idle();
        check("mis_rd_set", {31'b0, mis2}, 32'h1);
        step();
        check("mis_rd_clear", {31'b0, mis2}, 32'h0);
        check("mis_rd_data",  rdata2, 32'hDEADBEEF);

        // 0x40 + DEPTH*4 aliases word index 0x10; misaligned write flags too.
        do_write(32'h1043, 32'h0BADF00D);
        check("mis_wr_set", {31'b0, mis2}, 32'h1);
        rd_en = 1'b1; raddr = 32'h40;
        step();
        idle();
        check("mis_wr_clear", {31'b0, mis2}, 32'h0);
        step();
        check("alias_data", rdata2, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
